full_subtractor: RTL and testbench
==================================

Name: full_subtractor

Overview:
Parameterizable ripple-borrow full subtractor computing a - b - c (c = borrow-in), built from chained 1-bit full-subtractor cells. Provides a zero-latency combinational result plus a one-cycle registered copy with valid flag and a saturating borrow-event counter. Used wherever a small borrow-propagating subtract is needed, e.g. comparator or decrement paths.

Parameters:
WIDTH, 1, operand and difference width in bits (≥1); WIDTH=1 is the classic 1-bit full subtractor
CNT_W, 16, width of borrow_count

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  qualifies a/b/c for the registered stage
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
c  input  1  borrow-in
difference  output  WIDTH  combinational difference
barrow  output  1  combinational borrow-out
diff_q  output  WIDTH  registered difference
barrow_q  output  1  registered borrow-out
out_valid  output  1  diff_q/barrow_q hold a freshly captured result
borrow_count  output  CNT_W  saturating count of accepted ops with borrow-out=1

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Per-bit cell i, with bin0 = c and bin(i+1) = bout(i):
  - d(i) = a(i) ^ b(i) ^ bin(i)
  - bout(i) = (~a(i) & b(i)) | (~(a(i) ^ b(i)) & bin(i))
- difference = (a - b - c) mod 2^WIDTH; barrow = bout(WIDTH-1), i.e. 1 iff unsigned a < b + c.
- Combinational outputs depend only on a, b, c: no clock dependence, and valid during and after reset.
- WIDTH=1 truth table, listed as abc -> difference,barrow: 000->0,0; 001->1,1; 010->1,1; 011->0,1; 100->1,0; 101->0,0; 110->0,0; 111->1,1.
- Registered stage, at posedge clk:
  - out_valid <= in_valid.
  - If in_valid: diff_q <= difference; barrow_q <= barrow.
  - If !in_valid: diff_q and barrow_q hold their previous values.
  - Latency is 1 cycle from accepted inputs to diff_q/barrow_q/out_valid.
- borrow_count: increments by 1 on each clock edge where in_valid=1 and barrow=1. It saturates at 2^CNT_W-1 and never wraps.
- Reset: asserting rst immediately forces diff_q=0, barrow_q=0, out_valid=0, borrow_count=0, including mid-operation and regardless of in_valid. The first capture occurs on the first posedge after rst deasserts.
- Inputs X/Z are not required to be handled. No back-pressure; every in_valid cycle is accepted.

Optional Feature:
Macro FS_STATUS_EN.
- Defined: adds outputs zero_q (1 bit) and ovf_q (1 bit), registered with diff_q under the same in_valid qualification, and reset to 0.
  - zero_q = (difference == 0).
  - ovf_q = two's-complement signed overflow of a - b - c, i.e. (a[MSB] != b[MSB]) && (difference[MSB] != a[MSB]).
- Not defined: these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- WIDTH=1: sweep abc over 000..111, one step per 5 time units -> difference/barrow match the truth table above at each step, with no clock needed.
- WIDTH=8: a=0x10, b=0x01, c=1, in_valid=1, one clock -> difference=0x0E, barrow=0; next cycle diff_q=0x0E, barrow_q=0, out_valid=1.
- WIDTH=8: a=0x00, b=0x00, c=1 -> difference=0xFF, barrow=1. After the edge, borrow_count increments by 1. With in_valid=0 on the following cycles, diff_q holds 0xFF and out_valid=0.
- Counter saturation: CNT_W=4, apply 20 consecutive borrowing ops -> borrow_count stops at 15.
- Reset mid-stream: assert rst between clock edges while out_valid=1 and borrow_count=5 -> all registered outputs become 0 immediately, with no clock edge required. The combinational difference still tracks the inputs.
- FS_STATUS_EN, WIDTH=8: a=0x80, b=0x01, c=0 -> diff_q=0x7F, ovf_q=1, zero_q=0. a=0x05, b=0x04, c=1 -> zero_q=1, ovf_q=0.

Source files
------------

// File: rtl/full_subtractor.sv
// Ripple-borrow subtractor a - b - c built from chained 1-bit cells, with a registered
// copy, valid flag and saturating borrow counter. Define FS_STATUS_EN for zero_q/ovf_q.

module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module full_subtractor #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] difference,
  output logic             barrow,
  output logic [WIDTH-1:0] diff_q,
  output logic             barrow_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] borrow_count
`ifdef FS_STATUS_EN
  ,
  output logic             zero_q,
  output logic             ovf_q
`endif
);

  // Each stage keeps its own borrow scalars so the chain is not one self-referencing vector.
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    logic bin_l, bout_l;
    if (g == 0) begin : g_first
      assign bin_l = c;
    end else begin : g_next
      assign bin_l = g_cell[g-1].bout_l;
    end
    fs_cell u_cell (
      .a    (a[g]),
      .b    (b[g]),
      .bin  (bin_l),
      .d    (difference[g]),
      .bout (bout_l)
    );
  end

  assign barrow = g_cell[WIDTH-1].bout_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q    <= '0;
      barrow_q  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff_q   <= difference;
        barrow_q <= barrow;
      end
    end
  end

  // Saturates at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      borrow_count <= '0;
    else if (in_valid && barrow && (borrow_count != {CNT_W{1'b1}}))
      borrow_count <= borrow_count + 1'b1;
  end

`ifdef FS_STATUS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (in_valid) begin
      zero_q <= (difference == '0);
      ovf_q  <= (a[WIDTH-1] != b[WIDTH-1]) && (difference[WIDTH-1] != a[WIDTH-1]);
    end
  end
`endif

endmodule

// File: tb/tb_full_subtractor.sv
// Bench for full_subtractor: 1-bit truth table plus an 8-bit instance (CNT_W=4)
// checked through a scoreboard of expected registered results.

module tb_full_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 1-bit instance
  logic       iv1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       c1 = 1'b0;
  logic [0:0] d1, d1q;
  logic       bo1, bo1q, ov1;
  logic [15:0] cnt1;

  // 8-bit instance
  logic       in_valid = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       c = 1'b0;
  logic [7:0] difference, diff_q;
  logic       barrow, barrow_q, out_valid;
  logic [3:0] borrow_count;
`ifdef FS_STATUS_EN
  logic z1, o1, zero_q, ovf_q;
`endif

  full_subtractor #(.WIDTH(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .c(c1),
    .difference(d1), .barrow(bo1), .diff_q(d1q), .barrow_q(bo1q),
    .out_valid(ov1), .borrow_count(cnt1)
`ifdef FS_STATUS_EN
    , .zero_q(z1), .ovf_q(o1)
`endif
  );

  full_subtractor #(.WIDTH(8), .CNT_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .difference(difference), .barrow(barrow), .diff_q(diff_q), .barrow_q(barrow_q),
    .out_valid(out_valid), .borrow_count(borrow_count)
`ifdef FS_STATUS_EN
    , .zero_q(zero_q), .ovf_q(ovf_q)
`endif
  );

  typedef struct {logic a, b, c, d, bo;} v1_t;
  typedef struct {logic [7:0] a, b; logic c; logic [7:0] d; logic bo;} vec_t;
  typedef struct {logic [7:0] d; logic bo; logic [3:0] cnt; logic z, ov;} exp_t;

  exp_t sbq[$];
  int   exp_cnt = 0;
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one accepted op at the falling edge, check the combinational path, queue the result.
  task automatic drive(input logic [7:0] ta, tb, input logic tc,
                       input logic [7:0] td, input logic tbo);
    exp_t e;
    @(negedge clk);
    a = ta; b = tb; c = tc; in_valid = 1'b1;
    #1;
    chk("comb_diff", {24'd0, difference}, {24'd0, td});
    chk("comb_barrow", {31'd0, barrow}, {31'd0, tbo});
    if (tbo && exp_cnt < 15) exp_cnt++;
    e.d = td; e.bo = tbo; e.cnt = exp_cnt[3:0];
    e.z = (td == 8'h00);
    e.ov = (ta[7] != tb[7]) && (td[7] != ta[7]);
    sbq.push_back(e);
  endtask

  task automatic drive_model(input logic [7:0] ta, tb, input logic tc);
    logic [8:0] r;
    r = {1'b0, ta} - {1'b0, tb} - {8'd0, tc};
    drive(ta, tb, tc, r[7:0], r[8]);
  endtask

  // Scoreboard: every registered result pops one expected entry.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && out_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("diff_q", {24'd0, diff_q}, {24'd0, e.d});
        chk("barrow_q", {31'd0, barrow_q}, {31'd0, e.bo});
        chk("borrow_count", {28'd0, borrow_count}, {28'd0, e.cnt});
`ifdef FS_STATUS_EN
        chk("zero_q", {31'd0, zero_q}, {31'd0, e.z});
        chk("ovf_q", {31'd0, ovf_q}, {31'd0, e.ov});
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    v1_t  t1[8];
    vec_t tv[8];
    t1[0] = '{0,0,0, 0,0}; t1[1] = '{0,0,1, 1,1};
    t1[2] = '{0,1,0, 1,1}; t1[3] = '{0,1,1, 0,1};
    t1[4] = '{1,0,0, 1,0}; t1[5] = '{1,0,1, 0,0};
    t1[6] = '{1,1,0, 0,0}; t1[7] = '{1,1,1, 1,1};
    tv[0] = '{8'h10, 8'h01, 1'b1, 8'h0E, 1'b0};
    tv[1] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    tv[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tv[3] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    tv[4] = '{8'h05, 8'h04, 1'b1, 8'h00, 1'b0};
    tv[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
    tv[6] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    tv[7] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1};

    // Reset state, checked before any clock edge.
    #2;
    chk("rst_diff_q", {24'd0, diff_q}, 32'd0);
    chk("rst_barrow_q", {31'd0, barrow_q}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_borrow_count", {28'd0, borrow_count}, 32'd0);
    chk("rst1_out_valid", {31'd0, ov1}, 32'd0);

    // 1-bit truth table, swept while still in reset: purely combinational.
    for (int i = 0; i < 8; i++) begin
      a1 = t1[i].a; b1 = t1[i].b; c1 = t1[i].c;
      #5;
      chk($sformatf("tt1_diff_%0d", i), {31'd0, d1}, {31'd0, t1[i].d});
      chk($sformatf("tt1_borrow_%0d", i), {31'd0, bo1}, {31'd0, t1[i].bo});
    end

    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 8; i++) drive(tv[i].a, tv[i].b, tv[i].c, tv[i].d, tv[i].bo);

    // Hold: borrowing op then idle cycles keep diff_q.
    drive(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #2;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      chk("hold_diff_q", {24'd0, diff_q}, 32'hFF);
      chk("hold_barrow_q", {31'd0, barrow_q}, 32'd1);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd0);
    end

    for (int i = 0; i < 8; i++) drive_model(8'($urandom), 8'($urandom), 1'($urandom));

    // Saturation: 20 borrowing ops on a 4-bit counter.
    for (int i = 0; i < 20; i++) drive_model(8'h00, 8'h01, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #2;
    chk("sat_count", {28'd0, borrow_count}, 32'd15);

    // Fresh reset, then five borrowing ops and a reset between edges.
    @(negedge clk); rst = 1'b1; #1; rst = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 5; i++) drive_model(8'h03, 8'h04, 1'b0);
    @(posedge clk); #3;
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_count", {28'd0, borrow_count}, 32'd5);
    rst = 1'b1;
    #1;
    chk("mid_rst_diff_q", {24'd0, diff_q}, 32'd0);
    chk("mid_rst_barrow_q", {31'd0, barrow_q}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_count", {28'd0, borrow_count}, 32'd0);
    a = 8'h20; b = 8'h05; c = 1'b1;
    #1;
    chk("mid_rst_comb_diff", {24'd0, difference}, 32'h1A);
    chk("mid_rst_comb_barrow", {31'd0, barrow}, 32'd0);
    sbq.delete();
    exp_cnt = 0;
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;

    // First capture after reset release.
    drive_model(8'h01, 8'h02, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("sb_drain", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
